// File: rtl/wb_interconnect.sv
// Single-master, N-slave pipelined Wishbone B4 interconnect; one outstanding transaction.
// Define WB_IC_TIMEOUT_EN to enable the watchdog that turns a hung slave into a bus error.
module wb_interconnect #(
  parameter int                         NUM_SLAVES = 2,
  parameter logic [NUM_SLAVES*32-1:0]   SLV_PREFIX = {32'h8000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0]   SLV_MASK   = {32'hFFFF_8000, 32'hFFFF_8000},
  parameter int                         TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m_cyc_i,
  input  logic                    m_stb_i,
  input  logic                    m_we_i,
  input  logic [31:0]             m_adr_i,
  input  logic [3:0]              m_sel_i,
  input  logic [31:0]             m_dat_i,
  output logic [31:0]             m_dat_o,
  output logic                    m_ack_o,
  output logic                    m_err_o,
  output logic                    m_stall_o,
  output logic [NUM_SLAVES-1:0]   s_cyc_o,
  output logic [NUM_SLAVES-1:0]   s_stb_o,
  output logic                    s_we_o,
  output logic [31:0]             s_adr_o,
  output logic [3:0]              s_sel_o,
  output logic [31:0]             s_dat_o,
  input  logic [NUM_SLAVES*32-1:0] s_dat_i,
  input  logic [NUM_SLAVES-1:0]   s_ack_i,
  input  logic [NUM_SLAVES-1:0]   s_err_i,
  input  logic [NUM_SLAVES-1:0]   s_stall_i
);

  localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DERR} state_t;

  state_t                r_state, w_next;
  logic [IW-1:0]         r_tgt, w_idx;
  logic                  w_hit, w_accept;
  logic                  r_we;
  logic [31:0]           r_adr, r_wdat, r_mdat;
  logic [3:0]            r_sel;
  logic                  r_ack, r_err;
  logic                  w_set_ack, w_set_err;
  logic                  w_t_ack, w_t_err, w_t_stall;
  logic [31:0]           w_t_dat;
  logic [NUM_SLAVES-1:0] w_oh;
  logic                  w_wdt_exp;
  logic                  w_busy;

  // Scan downward so the lowest-index hitting window wins on overlap.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if ((m_adr_i & SLV_MASK[k*32 +: 32]) == SLV_PREFIX[k*32 +: 32]) begin
        w_hit = 1'b1;
        w_idx = IW'(k);
      end
    end
  end

  always_comb begin
    w_oh        = '0;
    w_oh[r_tgt] = 1'b1;
  end

  assign w_t_ack   = s_ack_i[r_tgt];
  assign w_t_err   = s_err_i[r_tgt];
  assign w_t_stall = s_stall_i[r_tgt];
  assign w_t_dat   = s_dat_i[{r_tgt, 5'b0} +: 32];
  assign w_accept  = m_cyc_i & m_stb_i & (r_state == ST_IDLE);
  assign w_busy    = (r_state == ST_REQ) || (r_state == ST_WAIT);

`ifdef WB_IC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_wdt;

  // Saturating: once expired it stays at TIMEOUT until the next acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_wdt <= '0;
    else if (w_accept)
      r_wdt <= '0;
    else if (w_busy && (r_wdt != CW'(TIMEOUT)))
      r_wdt <= r_wdt + 1'b1;
  end

  assign w_wdt_exp = (r_wdt == CW'(TIMEOUT));
`else
  assign w_wdt_exp = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    w_set_ack = 1'b0;
    w_set_err = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next    = w_hit ? ST_REQ : ST_DERR;
          w_set_err = ~w_hit;
        end
      end
      ST_REQ: begin
        if (!m_cyc_i) begin
          w_next = ST_IDLE;
        end else if (!w_t_stall && w_t_err) begin
          w_next    = ST_IDLE;
          w_set_err = 1'b1;
        end else if (!w_t_stall && w_t_ack) begin
          w_next    = ST_IDLE;
          w_set_ack = 1'b1;
        end else if (w_wdt_exp) begin
          w_next    = ST_DERR;
          w_set_err = 1'b1;
        end else if (!w_t_stall) begin
          w_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!m_cyc_i) begin
          w_next = ST_IDLE;
        end else if (w_t_err) begin
          w_next    = ST_IDLE;
          w_set_err = 1'b1;
        end else if (w_t_ack) begin
          w_next    = ST_IDLE;
          w_set_ack = 1'b1;
        end else if (w_wdt_exp) begin
          w_next    = ST_DERR;
          w_set_err = 1'b1;
        end
      end
      ST_DERR: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_tgt   <= '0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_sel   <= '0;
      r_wdat  <= '0;
      r_mdat  <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ack   <= w_set_ack;
      r_err   <= w_set_err;
      if (w_accept) begin
        r_tgt  <= w_idx;
        r_we   <= m_we_i;
        r_adr  <= m_adr_i;
        r_sel  <= m_sel_i;
        r_wdat <= m_dat_i;
      end
      if (w_set_ack && !r_we)
        r_mdat <= w_t_dat;
    end
  end

  // Slave qualifiers decode straight from state so reset drops them asynchronously.
  assign s_cyc_o   = w_busy ? w_oh : '0;
  assign s_stb_o   = (r_state == ST_REQ) ? w_oh : '0;
  assign s_we_o    = r_we;
  assign s_adr_o   = r_adr;
  assign s_sel_o   = r_sel;
  assign s_dat_o   = r_wdat;
  assign m_dat_o   = r_mdat;
  assign m_ack_o   = r_ack;
  assign m_err_o   = r_err;
  assign m_stall_o = (r_state != ST_IDLE);

endmodule

// File: tb/tb_wb_interconnect.sv
// Scoreboard bench for wb_interconnect: directed transactions, queued expected responses.
module tb_wb_interconnect;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_cyc_i, m_stb_i, m_we_i;
  logic [31:0] m_adr_i, m_dat_i;
  logic [3:0]  m_sel_i;
  logic [31:0] m_dat_o;
  logic        m_ack_o, m_err_o, m_stall_o;
  logic [1:0]  s_cyc_o, s_stb_o;
  logic        s_we_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic [63:0] s_dat_i;
  logic [1:0]  s_ack_i, s_err_i, s_stall_i;

  wb_interconnect #(.NUM_SLAVES(2), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_sel_i(m_sel_i), .m_dat_i(m_dat_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_stall_o(m_stall_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_stall_i(s_stall_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_err;
    logic        chk_dat;
    logic [31:0] dat;
  } resp_t;

  resp_t exp_q[$];
  resp_t mon_e;
  int    checks = 0;
  int    errors = 0;

  // Monitor: every response pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && (m_ack_o || m_err_o)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: ack=%0b err=%0b, required no response", m_ack_o, m_err_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.is_err) begin
          if (!(m_err_o && !m_ack_o)) begin
            errors++;
            $display("FAIL resp_kind: ack=%0b err=%0b, required err only", m_ack_o, m_err_o);
          end
        end else if (!(m_ack_o && !m_err_o)) begin
          errors++;
          $display("FAIL resp_kind: ack=%0b err=%0b, required ack only", m_ack_o, m_err_o);
        end else if (mon_e.chk_dat && (m_dat_o !== mon_e.dat)) begin
          errors++;
          $display("FAIL resp_data: got %h, required %h", m_dat_o, mon_e.dat);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat);
    int n;
    n = 0;
    while (m_stall_o && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (m_stall_o) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: stall=%0b, required 0", m_stall_o);
    end
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = we;
    m_adr_i = adr;  m_sel_i = sel;  m_dat_i = dat;
    @(posedge clk); #1;
    m_stb_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int first;
    logic seen;
    rst = 1'b1;
    m_cyc_i = 0; m_stb_i = 0; m_we_i = 0; m_adr_i = 0; m_sel_i = 0; m_dat_i = 0;
    s_dat_i = '0; s_ack_i = 0; s_err_i = 0; s_stall_i = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cyc", s_cyc_o, 0);
    chk("rst_stb", s_stb_o, 0);
    chk("rst_ack_err", {m_ack_o, m_err_o}, 0);
    chk("rst_stall", m_stall_o, 0);
    chk("rst_mdat", m_dat_o, 0);
    rst = 1'b0;

    // Read hit on slave1, ack in first slave cycle: latency 2.
    s_dat_i = {32'hDEAD_BEEF, 32'h0};
    exp_q.push_back({1'b0, 1'b1, 32'hDEAD_BEEF});
    issue(1'b0, 32'h8000_0010, 4'hF, 32'h0);
    s_ack_i = 2'b10;
    @(negedge clk);
    chk("t1_stb", s_stb_o, 2'b10);
    chk("t1_adr", s_adr_o, 32'h8000_0010);
    chk("t1_ack_early", m_ack_o, 0);
    @(posedge clk); #1; s_ack_i = 0;
    @(negedge clk);
    chk("t1_ack_latency", m_ack_o, 1);
    chk("t1_stall_low", m_stall_o, 0);
    @(negedge clk);
    chk("t1_ack_width", m_ack_o, 0);
    chk("t1_mdat", m_dat_o, 32'hDEAD_BEEF);
    m_cyc_i = 0;
    drain();

    // Stalled write to slave0: three stalled cycles, then ack.
    s_stall_i = 2'b01;
    exp_q.push_back({1'b0, 1'b0, 32'h0});
    issue(1'b1, 32'h0000_0004, 4'b0011, 32'h1234_5678);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_stb", s_stb_o, 2'b01);
      chk("t2_sdat", s_dat_o, 32'h1234_5678);
      chk("t2_sel", s_sel_o, 4'b0011);
      chk("t2_we", s_we_o, 1);
      if (i == 3) begin
        s_stall_i = 0;
        s_ack_i = 2'b01;
      end
    end
    @(posedge clk); #1; s_ack_i = 0;
    @(negedge clk);
    chk("t2_ack", m_ack_o, 1);
    chk("t2_stb_drop", s_stb_o, 0);
    chk("t2_mdat_kept", m_dat_o, 32'hDEAD_BEEF);
    m_cyc_i = 0;
    drain();

    // Unmapped address: decode error one cycle after acceptance.
    exp_q.push_back({1'b1, 1'b0, 32'h0});
    issue(1'b0, 32'h4000_0000, 4'hF, 32'h0);
    @(negedge clk);
    chk("t3_err", m_err_o, 1);
    chk("t3_cyc", s_cyc_o, 0);
    m_cyc_i = 0;
    drain();

    // Ack via WAIT on slave0, with a stray ack from slave1 during REQ.
    s_dat_i = {32'hFFFF_FFFF, 32'h0BAD_F00D};
    exp_q.push_back({1'b0, 1'b1, 32'h0BAD_F00D});
    issue(1'b0, 32'h0000_0100, 4'hF, 32'h0);
    s_ack_i = 2'b10;
    @(negedge clk);
    chk("t4_stb", s_stb_o, 2'b01);
    @(negedge clk);
    chk("t4_wait_stb", s_stb_o, 0);
    chk("t4_wait_cyc", s_cyc_o, 2'b01);
    chk("t4_no_ack", m_ack_o, 0);
    s_ack_i = 2'b01;
    @(posedge clk); #1; s_ack_i = 0;
    @(negedge clk);
    chk("t4_ack", m_ack_o, 1);
    chk("t4_mdat", m_dat_o, 32'h0BAD_F00D);
    m_cyc_i = 0;
    drain();

    // Slave error and ack together: error wins, read data untouched.
    s_dat_i = {32'hBADB_AD00, 32'h0};
    exp_q.push_back({1'b1, 1'b0, 32'h0});
    issue(1'b0, 32'h8000_0020, 4'hF, 32'h0);
    s_ack_i = 2'b10; s_err_i = 2'b10;
    @(posedge clk); #1; s_ack_i = 0; s_err_i = 0;
    @(negedge clk);
    chk("t5_err", m_err_o, 1);
    chk("t5_no_ack", m_ack_o, 0);
    chk("t5_mdat_kept", m_dat_o, 32'h0BAD_F00D);
    m_cyc_i = 0;
    drain();

    // Master abort in WAIT: cycle drops, late ack ignored.
    issue(1'b0, 32'h8000_0030, 4'hF, 32'h0);
    @(negedge clk);
    chk("t6_req_cyc", s_cyc_o, 2'b10);
    @(negedge clk);
    chk("t6_wait_cyc", s_cyc_o, 2'b10);
    m_cyc_i = 0;
    @(negedge clk);
    chk("t6_abort_cyc", s_cyc_o, 0);
    chk("t6_abort_stall", m_stall_o, 0);
    s_ack_i = 2'b10;
    @(negedge clk);
    s_ack_i = 0;
    chk("t6_no_ack", m_ack_o, 0);

`ifdef WB_IC_TIMEOUT_EN
    exp_q.push_back({1'b1, 1'b0, 32'h0});
    issue(1'b0, 32'h8000_0040, 4'hF, 32'h0);
    first = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (m_err_o && first == 0) first = n;
      if (n == 10) chk("t7_wdt_cyc", s_cyc_o, 0);
    end
    chk("t7_wdt_cycle", first, 10);
    m_cyc_i = 0;
    drain();
`else
    issue(1'b0, 32'h8000_0040, 4'hF, 32'h0);
    seen = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (m_err_o) seen = 1'b1;
    end
    chk("t7_no_wdt", seen, 0);
    chk("t7_still_cyc", s_cyc_o, 2'b10);
    m_cyc_i = 0;
    @(negedge clk);
    chk("t7_abort_cyc", s_cyc_o, 0);
`endif

    // Reset while in WAIT: outputs clear asynchronously, next request works.
    issue(1'b1, 32'h0000_0200, 4'hF, 32'hCAFE_0001);
    @(negedge clk);
    @(negedge clk);
    chk("t8_wait_cyc", s_cyc_o, 2'b01);
    rst = 1'b1;
    #1;
    chk("t8_rst_cyc", s_cyc_o, 0);
    chk("t8_rst_stb", s_stb_o, 0);
    chk("t8_rst_stall", m_stall_o, 0);
    chk("t8_rst_mdat", m_dat_o, 0);
    chk("t8_rst_sdat", s_dat_o, 0);
    chk("t8_rst_adr", s_adr_o, 0);
    chk("t8_rst_resp", {m_ack_o, m_err_o, s_we_o}, 0);
    m_cyc_i = 0;
    @(negedge clk);
    rst = 1'b0;
    s_dat_i = {32'h5555_AAAA, 32'h0};
    exp_q.push_back({1'b0, 1'b1, 32'h5555_AAAA});
    issue(1'b0, 32'h8000_0050, 4'hF, 32'h0);
    s_ack_i = 2'b10;
    @(posedge clk); #1; s_ack_i = 0;
    @(negedge clk);
    chk("t8_post_ack", m_ack_o, 1);
    chk("t8_post_mdat", m_dat_o, 32'h5555_AAAA);
    m_cyc_i = 0;
    drain();

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
